scope_capture_ctrl: RTL and testbench

- Sequences capture of the signal-generator output into the oscilloscope's sample RAM.
- Decimates the 16-bit input stream and waits for a level/slope trigger, or an auto-trigger timeout.
- Writes DEPTH consecutive samples, then holds the buffer frozen until the display side acknowledges a full frame, then re-arms.
- Sits between the signal generator and the oscilloscope's sample buffer, in the CLOCK_50 domain.

---
 rtl/scope_capture_ctrl.sv | 192 +++++++++++++++++++
 tb/tb_scope_capture_ctrl.sv | 603 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/scope_capture_ctrl.sv
// scope_capture_ctrl: decimating, triggered capture sequencer feeding the
// oscilloscope sample RAM in the CLOCK_50 domain.
//
// Ports:
//   CLOCK_50, RESET      clock, asynchronous active-high reset
//   run                  1 = capture enabled, 0 = abort to idle
//   signal               unsigned sample stream, valid every cycle
//   trig_level/slope     trigger threshold and direction (1 = rising)
//   auto_mode            enable timeout auto-trigger
//   decim                take one sample every decim+1 clocks
//   disp_done            display has read the frame (pulse)
//   wr_en/addr/data      registered sample RAM write port
//   capture_done         buffer holds a complete frame
//   auto_trig            last capture was started by the timeout
//   busy                 armed, waiting for trigger or capturing
module scope_capture_ctrl #(
   parameter int DATA_W       = 16,
   parameter int DEPTH        = 640,
   parameter int ADDR_W       = 10,
   parameter int AUTO_TIMEOUT = 1024
) (
   input  logic              CLOCK_50,
   input  logic              RESET,
   input  logic              run,
   input  logic [DATA_W-1:0] signal,
   input  logic [DATA_W-1:0] trig_level,
   input  logic              trig_slope,
   input  logic              auto_mode,
   input  logic [15:0]       decim,
   input  logic              disp_done,
   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [DATA_W-1:0] wr_data,
   output logic              capture_done,
   output logic              auto_trig,
   output logic              busy
);

   localparam int TW = $clog2(AUTO_TIMEOUT) + 1;
   localparam logic [TW-1:0] T_LAST = TW'(AUTO_TIMEOUT - 1);
   localparam logic [TW-1:0] T_MAX = '1;
   localparam logic [ADDR_W-1:0] A_LAST = ADDR_W'(DEPTH - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ARM,
      S_WAIT,
      S_CAPT,
      S_DONE
   } state_t;

   state_t state;
   state_t state_nx;

   logic [15:0]       dcnt;
   logic [15:0]       decim_q;
   logic [DATA_W-1:0] level_q;
   logic [DATA_W-1:0] prev_q;
   logic              slope_q;
   logic              auto_q;
   logic [TW-1:0]     tcnt;
   logic [ADDR_W-1:0] addr_q;

   logic              strobe;
   logic              hit;
   logic              wr;
   logic              fire_auto;
   logic              arm_entry;
   logic              busy_nx;
   logic              done_nx;
   logic [ADDR_W-1:0] wr_addr_nx;

   assign strobe = (state != S_IDLE) && (dcnt == decim_q);

   // Equal-to-level only counts when arriving from the strict side.
   always_comb begin
      if (slope_q)
         hit = (prev_q < level_q) && (signal >= level_q);
      else
         hit = (prev_q > level_q) && (signal <= level_q);
   end

   always_ff @(posedge CLOCK_50 or posedge RESET) begin
      if (RESET)
         state <= S_IDLE;
      else
         state <= state_nx;
   end

   always_comb begin
      state_nx   = state;
      wr         = 1'b0;
      fire_auto  = 1'b0;
      wr_addr_nx = addr_q;
      if (!run) begin
         state_nx = S_IDLE;
      end else begin
         unique case (state)
            S_IDLE: state_nx = S_ARM;
            S_ARM: begin
               if (strobe)
                  state_nx = S_WAIT;
            end
            S_WAIT: begin
               if (strobe && (hit || (auto_q && tcnt == T_LAST))) begin
                  wr         = 1'b1;
                  fire_auto  = !hit;
                  wr_addr_nx = '0;
                  state_nx   = S_CAPT;
               end
            end
            S_CAPT: begin
               if (strobe) begin
                  wr = 1'b1;
                  if (addr_q == A_LAST)
                     state_nx = S_DONE;
               end
            end
            // capture_done lags DONE entry by a cycle, so a disp_done in
            // the first DONE cycle is not taken.
            S_DONE: begin
               if (disp_done && capture_done)
                  state_nx = S_ARM;
            end
            default: state_nx = S_IDLE;
         endcase
      end
   end

   assign arm_entry = (state_nx == S_ARM) && (state != S_ARM);
   assign busy_nx   = (state_nx == S_ARM) || (state_nx == S_WAIT) ||
                      (state_nx == S_CAPT);
   assign done_nx   = (state == S_DONE) && (state_nx == S_DONE);

   always_ff @(posedge CLOCK_50 or posedge RESET) begin
      if (RESET) begin
         dcnt         <= '0;
         decim_q      <= '0;
         level_q      <= '0;
         slope_q      <= 1'b0;
         auto_q       <= 1'b0;
         prev_q       <= '0;
         tcnt         <= '0;
         addr_q       <= '0;
         wr_en        <= 1'b0;
         wr_addr      <= '0;
         wr_data      <= '0;
         capture_done <= 1'b0;
         auto_trig    <= 1'b0;
         busy         <= 1'b0;
      end else begin
         if (arm_entry) begin
            decim_q <= decim;
            level_q <= trig_level;
            slope_q <= trig_slope;
            auto_q  <= auto_mode;
         end

         // Restart the decimation phase on every arm.
         if (state_nx == S_IDLE || arm_entry || strobe)
            dcnt <= '0;
         else
            dcnt <= dcnt + 16'd1;

         if (strobe && (state == S_ARM || state == S_WAIT))
            prev_q <= signal;

         if (arm_entry)
            tcnt <= '0;
         else if (state == S_WAIT && strobe && !wr && tcnt != T_MAX)
            tcnt <= tcnt + TW'(1);

         if (wr && wr_addr_nx != A_LAST)
            addr_q <= wr_addr_nx + ADDR_W'(1);

         wr_en <= wr;
         if (wr) begin
            wr_addr <= wr_addr_nx;
            wr_data <= signal;
         end

         if (arm_entry)
            auto_trig <= 1'b0;
         else if (fire_auto)
            auto_trig <= 1'b1;

         capture_done <= done_nx;
         busy         <= busy_nx;
      end
   end

endmodule

// File: tb/tb_scope_capture_ctrl.sv
// tb_scope_capture_ctrl: scenario tasks against a strobe-sequence model
// of the capture controller.
module tb_scope_capture_ctrl;

   localparam int DEPTH = 640;
   localparam int AUTO  = 1024;

   localparam int K_SAW   = 0;
   localparam int K_CONST = 1;
   localparam int K_SINE  = 2;
   localparam int K_RAND  = 3;
   localparam int K_FLAT  = 4;

   logic        clk = 1'b0;
   logic        RESET;
   logic        run;
   logic [15:0] signal;
   logic [15:0] trig_level;
   logic        trig_slope;
   logic        auto_mode;
   logic [15:0] decim;
   logic        disp_done;
   logic        wr_en;
   logic [9:0]  wr_addr;
   logic [15:0] wr_data;
   logic        capture_done;
   logic        auto_trig;
   logic        busy;

   int errors = 0;
   int checks = 0;
   int cyc = 0;
   int wr_in_done = 0;

   logic [15:0] hist [0:65535];
   int w_edge[$];
   int w_addr[$];
   int w_data[$];
   int e_edge[$];
   int e_addr[$];
   int e_data[$];
   bit m_found;
   bit m_auto;
   string bad_msg;

   scope_capture_ctrl dut (
      .CLOCK_50    (clk),
      .RESET       (RESET),
      .run         (run),
      .signal      (signal),
      .trig_level  (trig_level),
      .trig_slope  (trig_slope),
      .auto_mode   (auto_mode),
      .decim       (decim),
      .disp_done   (disp_done),
      .wr_en       (wr_en),
      .wr_addr     (wr_addr),
      .wr_data     (wr_data),
      .capture_done(capture_done),
      .auto_trig   (auto_trig),
      .busy        (busy)
   );

   always #10 clk = ~clk;

   // Signal sampled at edge N is hist[N].
   initial begin
      signal = 16'h0;
      forever begin
         @(posedge clk);
         cyc = cyc + 1;
         #1 signal = hist[(cyc + 1) % 65536];
      end
   end

   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (wr_en === 1'b1) begin
            w_edge.push_back(cyc);
            w_addr.push_back(int'(wr_addr));
            w_data.push_back(int'(wr_data));
            if (capture_done === 1'b1)
               wr_in_done = wr_in_done + 1;
         end
      end
   end

   task automatic fill(int kind, int n, int p);
      for (int e = cyc + 2; e < cyc + 2 + n; e++) begin
         case (kind)
            K_SAW:   hist[e] = 16'(32'h7C00 + (e % 2048));
            K_CONST: hist[e] = 16'(p);
            K_SINE:  hist[e] = 16'(32768 +
                        int'(12288.0 * $sin(6.283185307 * e / 256.0)));
            K_RAND:  hist[e] = 16'($urandom);
            default: hist[e] = 16'(p + int'($urandom_range(0, 255)));
         endcase
      end
   endtask

   // Strobe n after arming at edge a lands on edge a+1+d+n*(d+1);
   // strobe 0 only seeds the previous sample.
   function automatic void model(int a, int d, int lvl, bit slope,
                                 bit am, int horizon);
      int s;
      int prev;
      int v;
      bit h;
      e_edge.delete();
      e_addr.delete();
      e_data.delete();
      m_found = 0;
      m_auto  = 0;
      s = a + 1 + d;
      prev = int'(hist[s]);
      for (int k = 1; k <= horizon; k++) begin
         s = s + d + 1;
         v = int'(hist[s]);
         h = slope ? (prev < lvl && v >= lvl) : (prev > lvl && v <= lvl);
         if (h || (am && k == AUTO)) begin
            m_found = 1;
            m_auto  = !h;
            break;
         end
         prev = v;
      end
      if (m_found)
         for (int j = 0; j < DEPTH; j++) begin
            e_edge.push_back(s + j * (d + 1));
            e_addr.push_back(j);
            e_data.push_back(int'(hist[s + j * (d + 1)]));
         end
   endfunction

   function automatic int score(int n);
      int bad = 0;
      bad_msg = "none";
      if (w_edge.size() != n) begin
         bad++;
         bad_msg = $sformatf("count %0d want %0d", w_edge.size(), n);
      end
      for (int i = 0; i < n && i < w_edge.size() && i < e_edge.size(); i++)
         if (w_edge[i] != e_edge[i] || w_addr[i] != e_addr[i] ||
             w_data[i] != e_data[i]) begin
            if (bad == 0)
               bad_msg = $sformatf(
                  "wr %0d got edge %0d addr %0d data %h want %0d %0d %h",
                  i, w_edge[i], w_addr[i], w_data[i],
                  e_edge[i], e_addr[i], e_data[i]);
            bad++;
         end
      return bad;
   endfunction

   function automatic int want_done();
      return m_found ? e_edge[DEPTH-1] + 1 : -1;
   endfunction

   task automatic clear_q();
      w_edge.delete();
      w_addr.delete();
      w_data.delete();
      wr_in_done = 0;
   endtask

   task automatic go_idle();
      run = 1'b0;
      disp_done = 1'b0;
      repeat (3) @(negedge clk);
      clear_q();
   endtask

   task automatic wait_done(int budget, output int seen);
      seen = -1;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (capture_done === 1'b1) begin
            seen = cyc;
            break;
         end
      end
   endtask

   task automatic wait_writes(int n, int budget, output bit ok);
      ok = 0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (w_edge.size() >= n) begin
            ok = 1;
            break;
         end
      end
   endtask

   task automatic wait_addr(int ad, int budget, output bit ok);
      ok = 0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (w_addr.size() > 0 && w_addr[w_addr.size()-1] == ad) begin
            ok = 1;
            break;
         end
      end
   endtask

   task automatic test_reset();
      RESET = 1'b1;
      #5;
      checks++;
      if ({wr_en, wr_addr, wr_data, capture_done, auto_trig, busy}
          !== 30'd0) begin
         errors++;
         $display("FAIL reset_outs: got %b want all 0",
            {wr_en, wr_addr, wr_data, capture_done, auto_trig, busy});
      end
      @(negedge clk);
      RESET = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if (busy !== 1'b0 || wr_en !== 1'b0) begin
         errors++;
         $display("FAIL idle_quiet: busy=%b wr_en=%b want 0 0", busy, wr_en);
      end
   endtask

   task automatic test_rising();
      int a;
      int seen;
      int b;
      go_idle();
      decim = 16'd0;
      trig_level = 16'h8000;
      trig_slope = 1'b1;
      auto_mode = 1'b0;
      fill(K_SAW, 5000, 0);
      a = cyc + 1;
      run = 1'b1;
      wait_done(5000, seen);
      model(a, 0, 'h8000, 1'b1, 1'b0, 3000);
      b = score(DEPTH);
      checks++;
      if (b != 0) begin
         errors++;
         $display("FAIL rise_writes: %0d bad, %s", b, bad_msg);
      end
      checks++;
      if (w_data.size() < DEPTH || w_data[0] != 'h8000 ||
          w_data[DEPTH-1] != 'h8000 + DEPTH - 1) begin
         errors++;
         $display("FAIL rise_data: got %0d writes first %h want 640 from 8000",
            w_data.size(), (w_data.size() > 0) ? w_data[0] : -1);
      end
      checks++;
      if (seen != want_done()) begin
         errors++;
         $display("FAIL rise_done: edge %0d want %0d", seen, want_done());
      end
      checks++;
      if (auto_trig !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL rise_flags: auto=%b busy=%b want 0 0", auto_trig, busy);
      end
   endtask

   task automatic test_decimation();
      int a;
      int seen;
      int b;
      int p0;
      int p1;
      int st;
      bit ok;
      go_idle();
      decim = 16'd3;
      trig_level = 16'h8000;
      trig_slope = 1'b1;
      auto_mode = 1'b0;
      fill(K_SAW, 8000, 0);
      a = cyc + 1;
      run = 1'b1;
      wait_writes(20, 6000, ok);
      decim = 16'd0;
      wait_done(6000, seen);
      model(a, 3, 'h8000, 1'b1, 1'b0, 1000);
      b = score(DEPTH);
      checks++;
      if (!ok || b != 0) begin
         errors++;
         $display("FAIL dec_writes: ok=%0d %0d bad, %s", ok, b, bad_msg);
      end
      p0 = (w_edge.size() >= 2) ? w_edge[1] - w_edge[0] : -1;
      p1 = (w_edge.size() >= DEPTH) ?
           w_edge[DEPTH-1] - w_edge[DEPTH-2] : -1;
      st = (w_data.size() >= 2) ? w_data[1] - w_data[0] : -1;
      checks++;
      if (p0 != 4) begin
         errors++;
         $display("FAIL dec_period: got %0d want 4", p0);
      end
      checks++;
      if (p1 != 4) begin
         errors++;
         $display("FAIL dec_latched: got %0d want 4", p1);
      end
      checks++;
      if (st != 4) begin
         errors++;
         $display("FAIL dec_step: got %0d want 4", st);
      end
   endtask

   task automatic test_auto();
      int a;
      int seen;
      int b;
      int drops;
      go_idle();
      decim = 16'd0;
      trig_level = 16'h8000;
      trig_slope = 1'b1;
      auto_mode = 1'b1;
      fill(K_CONST, 5000, 'h1234);
      a = cyc + 1;
      run = 1'b1;
      wait_done(3000, seen);
      model(a, 0, 'h8000, 1'b1, 1'b1, 2000);
      b = score(DEPTH);
      checks++;
      if (b != 0 || seen != want_done()) begin
         errors++;
         $display("FAIL auto_writes: %0d bad, %s, done %0d want %0d",
            b, bad_msg, seen, want_done());
      end
      checks++;
      if (w_edge.size() == 0 || w_edge[0] != a + 1 + AUTO ||
          w_data[0] != 'h1234) begin
         errors++;
         $display("FAIL auto_first: edge %0d want %0d",
            (w_edge.size() > 0) ? w_edge[0] : -1, a + 1 + AUTO);
      end
      checks++;
      if (auto_trig !== 1'b1) begin
         errors++;
         $display("FAIL auto_flag: got %b want 1", auto_trig);
      end
      go_idle();
      auto_mode = 1'b0;
      a = cyc + 1;
      run = 1'b1;
      drops = 0;
      @(negedge clk);
      for (int i = 0; i < 2500; i++) begin
         @(negedge clk);
         if (busy !== 1'b1)
            drops++;
      end
      checks++;
      if (w_edge.size() != 0) begin
         errors++;
         $display("FAIL noauto_writes: got %0d want 0", w_edge.size());
      end
      checks++;
      if (drops != 0) begin
         errors++;
         $display("FAIL noauto_busy: %0d cycles not busy want 0", drops);
      end
   endtask

   task automatic test_hold_rearm();
      int a;
      int seen;
      int b;
      bit ok;
      go_idle();
      decim = 16'd0;
      trig_level = 16'h8000;
      trig_slope = 1'b1;
      auto_mode = 1'b0;
      fill(K_SAW, 6000, 0);
      a = cyc + 1;
      run = 1'b1;
      wait_writes(100, 4000, ok);
      disp_done = 1'b1;
      @(negedge clk);
      disp_done = 1'b0;
      wait_addr(DEPTH - 1, 2000, ok);
      disp_done = 1'b1;
      @(negedge clk);
      disp_done = 1'b0;
      seen = (capture_done === 1'b1) ? cyc : -1;
      model(a, 0, 'h8000, 1'b1, 1'b0, 3000);
      b = score(DEPTH);
      checks++;
      if (!ok || b != 0) begin
         errors++;
         $display("FAIL hold_writes: ok=%0d %0d bad, %s", ok, b, bad_msg);
      end
      checks++;
      if (seen != want_done()) begin
         errors++;
         $display("FAIL hold_done: edge %0d want %0d", seen, want_done());
      end
      repeat (30) @(negedge clk);
      checks++;
      if (capture_done !== 1'b1 || busy !== 1'b0) begin
         errors++;
         $display("FAIL hold_frozen: done=%b busy=%b want 1 0",
            capture_done, busy);
      end
      checks++;
      if (w_edge.size() != DEPTH || wr_in_done != 0) begin
         errors++;
         $display("FAIL hold_nowrite: count %0d in_done %0d want 640 0",
            w_edge.size(), wr_in_done);
      end
      trig_level = 16'h8100;
      fill(K_SAW, 6000, 0);
      clear_q();
      a = cyc + 1;
      disp_done = 1'b1;
      @(negedge clk);
      disp_done = 1'b0;
      checks++;
      if (capture_done !== 1'b0 || busy !== 1'b1) begin
         errors++;
         $display("FAIL rearm_flags: done=%b busy=%b want 0 1",
            capture_done, busy);
      end
      wait_done(5000, seen);
      model(a, 0, 'h8100, 1'b1, 1'b0, 3000);
      b = score(DEPTH);
      checks++;
      if (b != 0 || w_data[0] != 'h8100) begin
         errors++;
         $display("FAIL rearm_writes: %0d bad, %s", b, bad_msg);
      end
   endtask

   task automatic test_falling_abort();
      int a;
      int b;
      bit ok;
      go_idle();
      decim = 16'd0;
      trig_level = 16'h8000;
      trig_slope = 1'b0;
      auto_mode = 1'b0;
      fill(K_SINE, 2000, 0);
      a = cyc + 1;
      run = 1'b1;
      wait_addr(300, 1500, ok);
      run = 1'b0;
      repeat (10) @(negedge clk);
      model(a, 0, 'h8000, 1'b0, 1'b0, 1000);
      b = score(301);
      checks++;
      if (!ok || b != 0) begin
         errors++;
         $display("FAIL fall_writes: ok=%0d %0d bad, %s", ok, b, bad_msg);
      end
      checks++;
      if (w_data.size() == 0 || w_data[0] > 'h8000) begin
         errors++;
         $display("FAIL fall_first: got %h want <= 8000",
            (w_data.size() > 0) ? w_data[0] : -1);
      end
      checks++;
      if (capture_done !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL abort_flags: done=%b busy=%b want 0 0",
            capture_done, busy);
      end
   endtask

   task automatic test_async_reset();
      int a;
      int seen;
      int b;
      bit ok;
      go_idle();
      decim = 16'd0;
      trig_level = 16'h8000;
      trig_slope = 1'b1;
      auto_mode = 1'b0;
      fill(K_SAW, 5000, 0);
      run = 1'b1;
      wait_writes(50, 4000, ok);
      #3 RESET = 1'b1;
      #1;
      checks++;
      if (!ok || {wr_en, wr_addr, wr_data, capture_done, auto_trig, busy}
          !== 30'd0) begin
         errors++;
         $display("FAIL async_reset: ok=%0d got %b want all 0", ok,
            {wr_en, wr_addr, wr_data, capture_done, auto_trig, busy});
      end
      @(negedge clk);
      fill(K_SAW, 5000, 0);
      clear_q();
      a = cyc + 1;
      RESET = 1'b0;
      @(posedge clk);
      #1;
      checks++;
      if (busy !== 1'b1 || wr_en !== 1'b0) begin
         errors++;
         $display("FAIL reset_arm: busy=%b wr_en=%b want 1 0", busy, wr_en);
      end
      wait_done(5000, seen);
      model(a, 0, 'h8000, 1'b1, 1'b0, 3000);
      b = score(DEPTH);
      checks++;
      if (b != 0 || seen != want_done()) begin
         errors++;
         $display("FAIL reset_recap: %0d bad, %s, done %0d want %0d",
            b, bad_msg, seen, want_done());
      end
   endtask

   task automatic test_random();
      int a;
      int d;
      int lvl;
      int seen;
      int b;
      bit sl;
      bit am;
      bit flat;
      go_idle();
      for (int it = 0; it < 4; it++) begin
         d    = int'($urandom_range(0, 2));
         lvl  = int'($urandom_range('h4000, 'hC000));
         sl   = 1'($urandom_range(0, 1));
         flat = (it % 2) == 1;
         am   = flat ? 1'b1 : 1'($urandom_range(0, 1));
         decim = 16'(d);
         trig_level = 16'(lvl);
         trig_slope = sl;
         auto_mode = am;
         if (flat)
            fill(K_FLAT, (d + 1) * (AUTO + DEPTH + 20) + 10, lvl + 'h1000);
         else
            fill(K_RAND, (d + 1) * (AUTO + DEPTH + 20) + 10, 0);
         clear_q();
         a = cyc + 1;
         if (it == 0) begin
            run = 1'b1;
            @(negedge clk);
         end else begin
            disp_done = 1'b1;
            @(negedge clk);
            disp_done = 1'b0;
         end
         wait_done((d + 1) * (AUTO + DEPTH + 20), seen);
         model(a, d, lvl, sl, am, AUTO + 10);
         b = score(m_found ? DEPTH : 0);
         checks++;
         if (b != 0) begin
            errors++;
            $display("FAIL rand%0d_writes: d=%0d lvl=%h sl=%0d am=%0d %0d bad, %s",
               it, d, lvl, sl, am, b, bad_msg);
         end
         checks++;
         if (auto_trig !== m_auto) begin
            errors++;
            $display("FAIL rand%0d_auto: got %b want %b", it, auto_trig, m_auto);
         end
         checks++;
         if (seen != want_done()) begin
            errors++;
            $display("FAIL rand%0d_done: edge %0d want %0d",
               it, seen, want_done());
         end
      end
   endtask

   initial begin
      for (int i = 0; i < 65536; i++)
         hist[i] = 16'h0;
      RESET = 1'b1;
      run = 1'b0;
      trig_level = 16'h0;
      trig_slope = 1'b1;
      auto_mode = 1'b0;
      decim = 16'd0;
      disp_done = 1'b0;
      repeat (2) @(negedge clk);
      test_reset();
      test_rising();
      test_decimation();
      test_auto();
      test_hold_rearm();
      test_falling_abort();
      test_async_reset();
      test_random();
      go_idle();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
